// File: rtl/alu_exec_unit_if.sv
// alu_exec_unit_if: request/response bundle for the execute-stage ALU.
//   master : drives the request (in_valid, alu_control, src_a, src_b) and out_ready
//   slave  : the ALU; drives in_ready and the registered result beat
//            (out_valid, result, zero, illegal)
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;

  modport master (
    output in_valid, alu_control, src_a, src_b, out_ready,
    input  in_ready, out_valid, result, zero, illegal
  );

  modport slave (
    input  in_valid, alu_control, src_a, src_b, out_ready,
    output in_ready, out_valid, result, zero, illegal
  );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: execute-stage ALU behind valid/ready handshakes.
//   clk    : rising-edge clock
//   reset  : synchronous, active-high
//   bus    : alu_exec_unit_if.slave (request in, registered result out)
// Codes: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed); anything else
// returns result 0 / zero 1 / illegal 1 as a normal beat.
// Optional feature macro ALU_MUL_EN: code 011 becomes an iterative
// shift-add multiply (low WIDTH bits, WIDTH cycles). Without it the unit
// is purely single-cycle and has no FSM.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  alu_exec_unit_if.slave   bus
);
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] op_res;
  logic             op_ill;
  logic             accept;

`ifdef ALU_MUL_EN
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam int         CW     = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_MUL} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
  logic             is_mul, mul_done;

  assign is_mul   = (bus.alu_control == OP_MUL);
  assign mul_done = (cnt == CW'(1));
  // Include the final cycle's partial product in the delivered result.
  assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

  assign bus.in_ready = !reset && (state == S_IDLE) && (!bus.out_valid || bus.out_ready);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
      S_MUL:   if (mul_done)         state_nxt = S_IDLE;
      default:                       state_nxt = S_IDLE;
    endcase
  end
`else
  assign bus.in_ready = !reset && (!bus.out_valid || bus.out_ready);
`endif

  assign accept = bus.in_valid && bus.in_ready;

  always_comb begin
    op_res = '0;
    op_ill = 1'b0;
    case (bus.alu_control)
      OP_AND: op_res = bus.src_a & bus.src_b;
      OP_OR:  op_res = bus.src_a | bus.src_b;
      OP_ADD: op_res = bus.src_a + bus.src_b;
      OP_SUB: op_res = bus.src_a - bus.src_b;
      // Native signed compare, so no overflow-prone subtract-and-sign trick.
      OP_SLT: op_res = {{(WIDTH-1){1'b0}}, ($signed(bus.src_a) < $signed(bus.src_b))};
`ifdef ALU_MUL_EN
      OP_MUL: op_res = '0;  // delivered by the multiplier path instead
`endif
      default: op_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.zero      <= 1'b0;
      bus.illegal   <= 1'b0;
`ifdef ALU_MUL_EN
      cnt           <= '0;
      acc           <= '0;
      mcand         <= '0;
      mplier        <= '0;
`endif
    end else begin
`ifdef ALU_MUL_EN
      if (state == S_MUL) begin
        acc    <= acc_nxt;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt - CW'(1);
        if (mul_done) begin
          bus.result    <= acc_nxt;
          bus.zero      <= (acc_nxt == '0);
          bus.illegal   <= 1'b0;
          bus.out_valid <= 1'b1;
        end
      end else if (accept && is_mul) begin
        // Accept implies the previous beat (if any) was consumed this edge.
        mcand         <= bus.src_a;
        mplier        <= bus.src_b;
        cnt           <= CW'(WIDTH);
        acc           <= '0;
        bus.out_valid <= 1'b0;
      end else
`endif
      if (accept) begin
        bus.result    <= op_res;
        bus.zero      <= (op_res == '0);
        bus.illegal   <= op_ill;
        bus.out_valid <= 1'b1;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  alu_exec_unit_if #(.WIDTH(WIDTH)) bus();
  alu_exec_unit #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  // All driving and sampling happens 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid    = 1'b1;
    bus.alu_control = op;
    bus.src_a       = a;
    bus.src_b       = b;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.out_ready = 1'b1;
    drive(3'b010, 32'd1, 32'd1);
    step();
    step();
    checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%0b exp=0", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%0b exp=0", bus.out_valid); end
    checks++; if (bus.result !== 32'd0) begin errors++; $display("FAIL rst_result got=%0h exp=0", bus.result); end
    checks++; if (bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin errors++; $display("FAIL rst_flags got=%0b%0b exp=00", bus.zero, bus.illegal); end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready got=%0b exp=1", bus.in_ready); end
    step();
  endtask

  task automatic test_add();
    drive(3'b010, 32'd5, 32'd7);
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%0b exp=1", bus.out_valid); end
    checks++; if (bus.result !== 32'd12) begin errors++; $display("FAIL add_result got=%0h exp=c", bus.result); end
    checks++; if (bus.zero !== 1'b0 || bus.illegal !== 1'b0) begin errors++; $display("FAIL add_flags got=%0b%0b exp=00", bus.zero, bus.illegal); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL add_consumed got=%0b exp=0", bus.out_valid); end
  endtask

  // Boundary vectors issued back to back with out_ready held high.
  task automatic test_vectors();
    logic [2:0]  op  [8];
    logic [31:0] a   [8];
    logic [31:0] b   [8];
    logic [31:0] exp [8];
    op[0]=3'b010; a[0]=32'hFFFF_FFFF; b[0]=32'd1;          exp[0]=32'd0;
    op[1]=3'b110; a[1]=32'd0;         b[1]=32'd1;          exp[1]=32'hFFFF_FFFF;
    op[2]=3'b111; a[2]=32'h8000_0000; b[2]=32'd1;          exp[2]=32'd1;
    op[3]=3'b111; a[3]=32'd1;         b[3]=32'h8000_0000;  exp[3]=32'd0;
    op[4]=3'b111; a[4]=32'h7FFF_FFFF; b[4]=32'h8000_0000;  exp[4]=32'd0;
    op[5]=3'b000; a[5]=32'hA5A5_A5A5; b[5]=32'hFF00_FF00;  exp[5]=32'hA500_A500;
    op[6]=3'b001; a[6]=32'hA5A5_0000; b[6]=32'h0000_5A5A;  exp[6]=32'hA5A5_5A5A;
    op[7]=3'b110; a[7]=32'h8000_0000; b[7]=32'd1;          exp[7]=32'h7FFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      drive(op[i], a[i], b[i]);
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== exp[i] || bus.zero !== (exp[i] == 32'd0) || bus.illegal !== 1'b0) begin
        errors++;
        $display("FAIL vec%0d got v=%0b r=%0h z=%0b i=%0b exp v=1 r=%0h z=%0b i=0", i, bus.out_valid, bus.result, bus.zero, bus.illegal, exp[i], exp[i] == 32'd0);
      end
    end
    bus.in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    drive(3'b110, 32'd9, 32'd9);
    step();
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b1) begin errors++; $display("FAIL b2b_sub got v=%0b r=%0h z=%0b exp v=1 r=0 z=1", bus.out_valid, bus.result, bus.zero); end
    drive(3'b111, 32'hFFFF_FFFF, 32'd1);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%0b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd1 || bus.zero !== 1'b0) begin errors++; $display("FAIL b2b_slt got v=%0b r=%0h z=%0b exp v=1 r=1 z=0", bus.out_valid, bus.result, bus.zero); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    drive(3'b000, 32'h0000_F0F0, 32'h0000_0FF0);
    step();
    drive(3'b001, 32'd1, 32'd2);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'h0000_00F0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall%0d got v=%0b r=%0h rdy=%0b exp v=1 r=f0 rdy=0", i, bus.out_valid, bus.result, bus.in_ready);
      end
      if (i < 3) step();
    end
    bus.out_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", bus.in_ready); end
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.result !== 32'd3) begin errors++; $display("FAIL bp_or got v=%0b r=%0h exp v=1 r=3", bus.out_valid, bus.result); end
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_illegal();
    logic [2:0] codes [3];
    codes[0] = 3'b100; codes[1] = 3'b101; codes[2] = 3'b011;
`ifdef ALU_MUL_EN
    for (int i = 0; i < 2; i++) begin
`else
    for (int i = 0; i < 3; i++) begin
`endif
      drive(codes[i], 32'd3, 32'd4);
      step();
      bus.in_valid = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd0 || bus.zero !== 1'b1 || bus.illegal !== 1'b1) begin
        errors++;
        $display("FAIL illegal_%0b got v=%0b r=%0h z=%0b i=%0b exp v=1 r=0 z=1 i=1", codes[i], bus.out_valid, bus.result, bus.zero, bus.illegal);
      end
      step();
      checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL illegal_one_beat got=%0b exp=0", bus.out_valid); end
    end
    // A legal op afterwards must clear the illegal flag.
    drive(3'b001, 32'd0, 32'd4);
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.illegal !== 1'b0 || bus.result !== 32'd4) begin errors++; $display("FAIL illegal_clear got i=%0b r=%0h exp i=0 r=4", bus.illegal, bus.result); end
    step();
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int low;
    low = 0;
    drive(3'b011, a, b);
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.in_ready === 1'b0 && bus.out_valid === 1'b0) low++;
      step();
    end
    checks++; if (low !== WIDTH) begin errors++; $display("FAIL mul_busy_cycles got=%0d exp=%0d", low, WIDTH); end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.result !== exp || bus.zero !== (exp == 32'd0) || bus.illegal !== 1'b0) begin
      errors++;
      $display("FAIL mul_result got v=%0b r=%0h z=%0b i=%0b exp v=1 r=%0h i=0", bus.out_valid, bus.result, bus.zero, bus.illegal, exp);
    end
    step();
    checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL mul_drain got v=%0b rdy=%0b exp v=0 rdy=1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_mul_reset();
    int seen;
    seen = 0;
    drive(3'b011, 32'h0000_1234, 32'h0000_0010);
    step();
    bus.in_valid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    step();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mulrst_valid got=%0b exp=0", bus.out_valid); end
    reset = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mulrst_in_ready got=%0b exp=1", bus.in_ready); end
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid === 1'b1) seen++;
      step();
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mulrst_no_beat got=%0d exp=0", seen); end
  endtask
`else
  task automatic test_mul_disabled();
    drive(3'b011, 32'h0000_1234, 32'h0000_0010);
    step();
    bus.in_valid = 1'b0;
    checks++; if (bus.out_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.result !== 32'd0) begin errors++; $display("FAIL mul_disabled got v=%0b i=%0b r=%0h exp v=1 i=1 r=0", bus.out_valid, bus.illegal, bus.result); end
    step();
  endtask
`endif

  initial begin
    reset           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.alu_control = 3'b000;
    bus.src_a       = '0;
    bus.src_b       = '0;
    bus.out_ready   = 1'b1;
    test_reset();
    test_add();
    test_vectors();
    test_back_to_back();
    test_backpressure();
    test_illegal();
`ifdef ALU_MUL_EN
    test_mul(32'h0000_1234, 32'h0000_0010, 32'h0001_2340);
    test_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    test_mul(32'h0000_0000, 32'h0000_0005, 32'h0000_0000);
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
